// File: rtl/upg_loader.sv
// UART programming loader: parses LEN | BASE | LEN x 32-bit LE words from a byte
// stream and issues one-cycle word writes to the instruction/data RAM programming ports.
module upg_loader #(
  parameter int unsigned ADDR_W  = 15,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              upg_wen_o,
  output logic [ADDR_W-1:0] upg_adr_o,
  output logic [31:0]       upg_dat_o,
  output logic              upg_done_o,
  output logic              busy,
  output logic              err
);

  localparam int unsigned GAP_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_ADR0,
    S_ADR1,
    S_DATA,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] word_idx_q, word_idx_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       buf_q, buf_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [31:0]       dat_q, dat_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              timed_c;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      base_q     <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      buf_q      <= '0;
      gap_q      <= '0;
      wen_q      <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      base_q     <= base_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      buf_q      <= buf_d;
      gap_q      <= gap_d;
      wen_q      <= wen_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  // Next-state, frame parsing and write generation
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    base_d     = base_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    buf_d      = buf_q;
    gap_d      = gap_q;
    wen_d      = 1'b0;
    adr_d      = adr_q;
    dat_d      = dat_q;
    err_d      = err_q;
    timed_c    = (state_q == S_LEN1) || (state_q == S_ADR0) ||
                 (state_q == S_ADR1) || (state_q == S_DATA);

    if (start) begin
      // start overrides everything, including a byte arriving this cycle
      state_d    = S_LEN0;
      len_d      = '0;
      base_d     = '0;
      word_idx_d = '0;
      byte_idx_d = '0;
      gap_d      = '0;
      err_d      = 1'b0;
    end else if (rx_valid && (state_q != S_IDLE) && (state_q != S_DONE)) begin
      gap_d = '0;
      case (state_q)
        S_LEN0: begin
          len_d   = ADDR_W'(rx_data);
          state_d = S_LEN1;
        end
        S_LEN1: begin
          len_d   = ADDR_W'({rx_data, len_q[7:0]});
          state_d = S_ADR0;
        end
        S_ADR0: begin
          base_d  = ADDR_W'(rx_data);
          state_d = S_ADR1;
        end
        S_ADR1: begin
          base_d     = ADDR_W'({rx_data, base_q[7:0]});
          word_idx_d = '0;
          byte_idx_d = '0;
          state_d    = (len_q == '0) ? S_DONE : S_DATA;
        end
        S_DATA: begin
          case (byte_idx_q)
            2'd0:    buf_d[7:0]   = rx_data;
            2'd1:    buf_d[15:8]  = rx_data;
            2'd2:    buf_d[23:16] = rx_data;
            default: buf_d[31:24] = rx_data;
          endcase
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            wen_d      = 1'b1;
            dat_d      = {rx_data, buf_q[23:0]};
            adr_d      = base_q + word_idx_q;
            word_idx_d = word_idx_q + ADDR_W'(1);
            if (word_idx_q == (len_q - ADDR_W'(1))) begin
              state_d = S_DONE;
            end
          end
        end
        default: ;
      endcase
    end else if (timed_c) begin
      // Inter-byte gap watchdog; abort drops any partial word
      if (gap_q == GAP_W'(TIMEOUT - 1)) begin
        state_d    = S_IDLE;
        err_d      = 1'b1;
        byte_idx_d = '0;
        gap_d      = '0;
      end else begin
        gap_d = gap_q + GAP_W'(1);
      end
    end

    done_d = (state_d == S_DONE);
    busy_d = (state_d == S_LEN0) || (state_d == S_LEN1) || (state_d == S_ADR0) ||
             (state_d == S_ADR1) || (state_d == S_DATA);
  end

  assign upg_wen_o  = wen_q;
  assign upg_adr_o  = adr_q;
  assign upg_dat_o  = dat_q;
  assign upg_done_o = done_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: doc/upg_loader.md
Name: upg_loader

Overview:
- UART programming loader; sits between the UART byte receiver and the instruction/data RAM programming ports.
- Parses a length-prefixed byte stream and packs bytes into 32-bit little-endian words.
- Drives the UPG write-enable, address, data and done signals consumed by the RAM wrappers.
- Address bit 14 selects the target: 0 = instruction RAM, 1 = data RAM. The host encodes this in the start address.

Parameters:
- ADDR_W, 15: width of upg_adr_o and of the word counter.
- TIMEOUT, 1000000: maximum idle clk cycles allowed between bytes inside a frame before the frame aborts.

Ports:
- clk  input  1  system clock (10 MHz UPG domain).
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; arms the loader, clears upg_done_o and err.
- rx_data  input  8  received byte; valid only when rx_valid=1.
- rx_valid  input  1  single-cycle byte strobe from the UART receiver.
- upg_wen_o  output  1  one-cycle write pulse to RAM.
- upg_adr_o  output  ADDR_W  word address of the current write.
- upg_dat_o  output  32  word data of the current write.
- upg_done_o  output  1  level; high after a complete frame has been written.
- busy  output  1  high in LEN0, LEN1, ADR0, ADR1, DATA.
- err  output  1  sticky; set on timeout abort.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. upg_wen_o=0, upg_adr_o=0, upg_dat_o=0, upg_done_o=0, busy=0, err=0. Internal counters and byte buffer cleared.
- Frame format: LEN (2 bytes, LE) | BASE (2 bytes, LE) | LEN words × 4 bytes each (LE).
- LEN and BASE each take bits [14:0]. Bit 15 of each is ignored.
- IDLE: rx_valid is ignored. start -> LEN0.
- LEN0: byte -> len[7:0]; next state LEN1.
- LEN1: byte -> len[14:8]; next state ADR0.
- ADR0: byte -> base[7:0]; next state ADR1.
- ADR1: byte -> base[14:8]; word_idx=0, byte_idx=0.
  - If len==0: go to DONE.
  - Otherwise: go to DATA.
- DATA: each byte is stored in buf[byte_idx*8 +: 8]; byte_idx increments and wraps 3->0.
  - On the byte that completes a word (byte_idx==3): in the following cycle upg_wen_o=1 for exactly one cycle, with upg_dat_o={b3,b2,b1,b0} and upg_adr_o=base+word_idx, truncated to ADDR_W (wraps modulo 2^15).
  - word_idx increments on that write.
  - If word_idx==len-1 at the write: transition to DONE in the same cycle as the write pulse.
- Write latency: exactly 1 cycle from the 4th byte's rx_valid to upg_wen_o.
- upg_adr_o and upg_dat_o hold their last values between writes.
- DONE: upg_done_o=1 and held. rx_valid is ignored. start -> LEN0 and upg_done_o drops in the next cycle.
- Timeout: applies in states LEN1, ADR0, ADR1 and DATA.
  - A gap counter resets on every rx_valid.
  - When the counter reaches TIMEOUT: state -> IDLE, err=1, upg_done_o=0, no write issued, and the partial word is discarded.
  - LEN0 has no timeout (waiting for the host).
- start in any state, including mid-frame: restart at LEN0; counters cleared; err=0; upg_done_o=0.
  - A pending write pulse scheduled for the same cycle is still issued.
- start and rx_valid in the same cycle: start wins and the byte is dropped.
- Back-to-back rx_valid on consecutive cycles is supported. No byte may be lost.
- Arithmetic: the len and word_idx comparison is done in ADDR_W bits. len max is 32767 words.

Test Plan:
- Reset then start; bytes 02 00 00 00 | 78 56 34 12 | EF BE AD DE -> wen pulses at adr 0x0000 dat 0x12345678 and at adr 0x0001 dat 0xDEADBEEF, each 1 cycle after its 4th byte; upg_done_o=1 after the second pulse; busy=0.
- Data-RAM target: LEN=1, BASE=0x4000, word 0xCAFEF00D -> single write at adr 0x4000; done=1.
- Length zero: bytes 00 00 10 00 -> no wen pulse; done=1 the cycle after the 4th byte.
- Timeout (TIMEOUT=16 in bench): LEN=1, BASE=0, then 2 data bytes, then silence for 16 cycles -> state IDLE, err=1, done=0, no wen. A subsequent start clears err.
- Restart mid-frame: start during DATA after 5 bytes, with start coincident with an rx_valid -> byte dropped, loader in LEN0. A new full frame (LEN=1, BASE=3, 0x00000001) writes adr 3 only.
- Async reset asserted mid-DATA -> all outputs 0 immediately; no wen after release until start.
